mult_share_arb: RTL
===================

# mult_share_arb

Round-robin arbiter and sequencer that shares one combinational unsigned multiplier among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, registers the product, and returns it on a single response channel tagged with the requester index. It sits between the client blocks and the shared `binary_nbit_multiplier` datapath.

## Interface
Parameters:
- `WIDTH`, default 2: operand width in bits; product width is 2*WIDTH.
- `NREQ`, default 4: number of requesters, must be at least 2; `IDW` = $clog2(NREQ).

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, NREQ: per-requester request valid.
- `req_ready`, out, NREQ: per-requester accept; at most one bit high.
- `req_a`, in, NREQ*WIDTH: operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`, in, NREQ*WIDTH: operand B; same packing as `req_a`.
- `rsp_valid`, out, 1: product available.
- `rsp_ready`, in, 1: consumer accepts the product.
- `rsp_product`, out, 2*WIDTH: registered a*b.
- `rsp_id`, out, IDW: index of the requester that owns `rsp_product`.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate among requesters.
  - CALC: compute the product.
  - RESP: present the response.
- IDLE:
  - Grant `g` = the first i with `req_valid[i]` high, scanning from `rr_ptr` upward with wrap at NREQ-1 to 0.
  - `req_ready[g]` is driven combinationally high in IDLE only; it is 0 in every other state.
  - Handshake (`req_valid[g]` & `req_ready[g]`) does all of the following:
    - latches `op_a`, `op_b` and `op_id = g`;
    - sets `rr_ptr <= (g+1) mod NREQ`;
    - moves to CALC.
  - With no valid request, IDLE holds and `rr_ptr` is unchanged.
- CALC: `rsp_product <= op_a*op_b` (full 2*WIDTH, unsigned, no truncation); `rsp_id <= op_id`; `rsp_valid <= 1`; move to RESP.
- RESP:
  - `rsp_valid` stays high, and `rsp_product` and `rsp_id` stay stable, until `rsp_ready` is high at a clock edge.
  - On that edge: `rsp_valid <= 0`, move to IDLE.
  - `rsp_product` and `rsp_id` hold their last values after the response is consumed.
- Requesters hold valid and operands stable until ready. The block samples the operands only at the accept edge.
- Operand changes by non-granted requesters have no effect.
- `rsp_ready` is ignored outside RESP.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0;
  - `rsp_valid` 0, `rsp_product` 0, `rsp_id` 0, `busy` 0;
  - `req_ready` follows IDLE arbitration immediately after reset release.
- Latency: accept at edge k, then `rsp_valid` is high after edge k+1.
- With `rsp_ready` tied high, the response is consumed at edge k+2 and the next accept can happen at edge k+3. Peak throughput is one multiply per 3 cycles.
- Backpressure: each cycle `rsp_ready` is low extends RESP by one cycle. No request is accepted during RESP.
- Simultaneous requests are resolved strictly by `rr_ptr`. With all NREQ requesters active, grant order is rr_ptr, rr_ptr+1, … with wrap.
- Reset asserted mid-operation immediately (asynchronously) forces:
  - IDLE, `rsp_valid` 0, `req_ready` 0 while `rst_n` is low;
  - the in-flight operation is dropped and never responded.
- Boundary: the maximum operands (2^WIDTH−1)² fit exactly in 2*WIDTH bits.

## Structure
- Shared package `mult_share_pkg` holds:
  - state enum `IDLE`/`CALC`/`RESP` and its 2-bit encoding;
  - helper function for the round-robin first-one-from-pointer search.
- Sub-module `binary_nbit_multiplier`: parameterised WIDTH, combinational, ports `a`, `b`, `product`. It is instantiated once and fed from `op_a`/`op_b`.
- Arbitration and FSM stay in `mult_share_arb`.

## Test plan
- Single request: requester 0 sends a=3, b=3 → `req_ready[0]` high in IDLE; `rsp_valid` after 2 edges; `rsp_product`=9, `rsp_id`=0.
- Contention: requesters 1 and 2 both valid from reset (`rr_ptr`=0) → 1 is served first, then 2; products correct; `req_ready` one-hot throughout.
- Fairness: all 4 requesters held valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0,1 over six operations.
- Backpressure: a=2, b=3 is accepted, then `rsp_ready` is held low for 5 cycles → `rsp_valid` stays high; `rsp_product`=6 and `rsp_id` stay stable; no `req_ready` asserted; IDLE is reached the cycle after `rsp_ready` rises.
- Reset mid-operation: `rst_n` is pulled low in CALC → `rsp_valid`=0 and `busy`=0 immediately; after release, `rr_ptr`=0 and the next grant goes to the lowest valid index.
- Exhaustive: 16 operand pairs for WIDTH=2, spread across random requesters → every product matches a*b with the correct `rsp_id`.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
package mult_share_pkg;

    // Sequencer states: arbitrate, multiply, hold the response.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        RESP = 2'b10
    } state_t;

    // Widest requester vector the round-robin search handles.
    localparam int MAX_NREQ = 32;
    localparam int MAX_IDW  = $clog2(MAX_NREQ);

    // Index of the first set bit of valid[nreq-1:0], scanning upward from ptr
    // with wrap-around. The scan runs from the far end back toward ptr so the
    // last hit written is the nearest one, which avoids an early-exit flag.
    // Returns ptr when no bit is set; callers qualify the result separately.
    function automatic int rr_first(input logic [MAX_NREQ-1:0] valid,
                                    input int                  ptr,
                                    input int                  nreq);
        int idx;
        int found;
        found = ptr;
        for (int k = MAX_NREQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                idx = ptr + k;
                if (idx >= nreq) begin
                    idx = idx - nreq;
                end
                if (valid[MAX_IDW'(idx)]) begin
                    found = idx;
                end
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/binary_nbit_multiplier.sv
// Combinational unsigned WIDTH x WIDTH multiplier with a full-width product.
module binary_nbit_multiplier #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;

    // Operands are widened first so the product is never truncated.
    assign product = PW'(a) * PW'(b);

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter and sequencer sharing one multiplier among NREQ
// requesters. One operation takes IDLE -> CALC -> RESP, so peak throughput
// is one product every three cycles.
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter  int WIDTH = 2,
    parameter  int NREQ  = 4,   // 2 .. MAX_NREQ
    localparam int IDW   = $clog2(NREQ),
    localparam int PW    = 2 * WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [PW-1:0]         rsp_product,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);

    state_t          r_state;
    state_t          w_state_next;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  w_grant;
    logic            w_any_valid;
    logic            w_accept;
    logic [NREQ-1:0] w_req_ready;

    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [IDW-1:0]   r_op_id;
    logic [PW-1:0]    w_product;
    logic [PW-1:0]    r_rsp_product;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_rsp_valid;

    // Round-robin grant candidate: first valid requester at or after r_rr_ptr.
    assign w_any_valid = |req_valid;
    assign w_grant     = IDW'(rr_first(MAX_NREQ'(req_valid), int'(r_rr_ptr), NREQ));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode.
    // NOTE: every output of this block is defaulted first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = '0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                // NOTE: rst_n gates ready directly so no requester sees an
                // accept while reset is held, even though the state is IDLE.
                if (rst_n && w_any_valid) begin
                    w_req_ready[w_grant] = 1'b1;
                    w_accept             = 1'b1;
                    w_state_next         = CALC;
                end
            end
            CALC: begin
                w_state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand capture at accept and round-robin pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op_id  <= '0;
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_op_a   <= req_a[w_grant*WIDTH +: WIDTH];
            r_op_b   <= req_b[w_grant*WIDTH +: WIDTH];
            r_op_id  <= w_grant;
            r_rr_ptr <= (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + 1'b1;
        end
    end

    binary_nbit_multiplier #(
        .WIDTH (WIDTH)
    ) u_mult (
        .a       (r_op_a),
        .b       (r_op_b),
        .product (w_product)
    );

    // Response register: loaded in CALC, held through RESP and afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_product <= '0;
            r_rsp_id      <= '0;
            r_rsp_valid   <= 1'b0;
        end else if (r_state == CALC) begin
            r_rsp_product <= w_product;
            r_rsp_id      <= r_op_id;
            r_rsp_valid   <= 1'b1;
        end else if (r_state == RESP && rsp_ready) begin
            r_rsp_valid   <= 1'b0;
        end
    end

    assign req_ready   = w_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_product = r_rsp_product;
    assign rsp_id      = r_rsp_id;
    assign busy        = (r_state != IDLE);

endmodule
